mem_xfer_ctrl: RTL and testbench

MEM_XFER_CTRL -- requirements
Module: mem_xfer_ctrl

---
 rtl/mem_xfer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_xfer_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// mem_xfer_ctrl
//
// Sequences a block transfer: for each word i in [0, len) it reads two source
// memories at src_base+i (shared address), waits one cycle for their
// synchronous read data, captures the external adder result ADDOut, and writes
// that sum to the destination memory at dst_base+i. Addresses wrap modulo
// 2^AW and the sum wraps modulo 2^DW (the adder has no carry out).
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   start           transfer request, only looked at in IDLE
//   src_base        first read address  (captured with start)
//   dst_base        first write address (captured with start)
//   len             word count          (captured with start, 0 = no words)
//   ADDOut          combinational sum of the two source memory outputs
//   RdEn, RdAddr    read strobe / shared read address to both source memories
//   WrEn, WrAddr    write strobe / address to the destination memory
//   DIn             destination write data
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse
//   dbg_state       current FSM state encoding, for observation only
//
// Handshake: there is no ready/valid back-pressure. A transfer is accepted on
// any clock edge where the block is in IDLE and start=1; the parameters are
// captured on that same edge and later changes on the inputs (including
// further start pulses) are ignored until the block is back in IDLE.
//
// Every word takes exactly three cycles (READ, WAIT, WRITE), so done appears
// in cycle 3*len+1 after the accepting edge (cycle 1 for len=0).
// -----------------------------------------------------------------------------
module mem_xfer_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] ADDOut,
  output logic          RdEn,
  output logic [AW-1:0] RdAddr,
  output logic          WrEn,
  output logic [AW-1:0] WrAddr,
  output logic [DW-1:0] DIn,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] ONE_AW = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] src_q,   src_d;
  logic [AW-1:0] dst_q,   dst_d;
  logic [AW-1:0] len_q,   len_d;
  logic [AW-1:0] idx_q,   idx_d;
  logic [DW-1:0] sum_q,   sum_d;

  // Word index of the last word; only meaningful while len_q != 0, which is
  // guaranteed whenever the FSM is in READ/WAIT/WRITE.
  logic          last_word;
  assign last_word = (idx_q == (len_q - ONE_AW));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = len;
          idx_d   = '0;
          state_d = (len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Source memories present data this cycle; ADDOut is their sum.
        sum_d   = ADDOut;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ONE_AW;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state and registers only, so nothing on start or
  // ADDOut can reach an output in the same cycle. Address/data buses are held
  // at zero outside their strobe state to keep them quiet and reset-clean.
  // ---------------------------------------------------------------------------
  always_comb begin
    RdEn   = 1'b0;
    RdAddr = '0;
    WrEn   = 1'b0;
    WrAddr = '0;
    DIn    = '0;
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);

    if (state_q == S_READ) begin
      RdEn   = 1'b1;
      RdAddr = src_q + idx_q;
    end

    if (state_q == S_WRITE) begin
      WrEn   = 1'b1;
      WrAddr = dst_q + idx_q;
      DIn    = sum_q;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_xfer_ctrl
//
// Drives mem_xfer_ctrl with two behavioural source memories (one-cycle
// synchronous read), a combinational adder and a destination memory. The
// reference model works at transfer level: for a transfer (src, dst, len) it
// lists the read addresses, the write address/data pairs and the final
// destination image, and it predicts the per-cycle strobe pattern from the
// three-cycles-per-word rule. Observed activity is matched against those
// expected queues.
// -----------------------------------------------------------------------------
module tb_mem_xfer_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT and its memories
  // ---------------------------------------------------------------------------
  logic          start;
  logic [AW-1:0] src_base, dst_base, len;
  logic [DW-1:0] add_out;
  logic          rd_en, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] din;
  logic [2:0]    dbg_state;

  mem_xfer_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .ADDOut   (add_out),
    .RdEn     (rd_en),
    .RdAddr   (rd_addr),
    .WrEn     (wr_en),
    .WrAddr   (wr_addr),
    .DIn      (din),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] mem_c [DEPTH];
  logic [DW-1:0] qa, qb;
  logic          clr_c;

  always @(posedge clk) begin
    if (rd_en) begin
      qa <= mem_a[rd_addr];
      qb <= mem_b[rd_addr];
    end
  end

  always @(posedge clk) begin
    if (clr_c) begin
      for (int k = 0; k < DEPTH; k++) mem_c[k] <= '0;
    end else if (wr_en) begin
      mem_c[wr_addr] <= din;
    end
  end

  assign add_out = qa + qb;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [DW-1:0] exp_wd_q[$];
  logic [DW-1:0] exp_c [DEPTH];
  logic [AW-1:0] obs_rd_q[$];
  logic [AW-1:0] obs_wa_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transfer-level model: what must be read, what must be written.
  task automatic model_xfer(input int s, input int d, input int l);
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    for (int k = 0; k < l; k++) begin
      int ra, wa;
      logic [DW-1:0] sum;
      ra  = (s + k) % DEPTH;
      wa  = (d + k) % DEPTH;
      sum = DW'((int'(mem_a[ra]) + int'(mem_b[ra])) % (1 << DW));
      exp_rd_q.push_back(AW'(ra));
      exp_wa_q.push_back(AW'(wa));
      exp_wd_q.push_back(sum);
      exp_c[wa] = sum;
    end
  endtask

  task automatic check_mem_c(input string tag);
    for (int k = 0; k < DEPTH; k++) check_eq(tag, 32'(mem_c[k]), 32'(exp_c[k]));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},   32'(busy),    0);
    check_eq({tag, "_done"},   32'(done),    0);
    check_eq({tag, "_rden"},   32'(rd_en),   0);
    check_eq({tag, "_wren"},   32'(wr_en),   0);
    check_eq({tag, "_rdaddr"}, 32'(rd_addr), 0);
    check_eq({tag, "_wraddr"}, 32'(wr_addr), 0);
    check_eq({tag, "_din"},    32'(din),     0);
  endtask

  // Per-cycle observation of a running transfer (c = cycles after start edge).
  task automatic observe_cycle(input int c, input int l);
    check_eq("busy", 32'(busy), 1);
    check_eq("rd_wr_excl", 32'(rd_en & wr_en), 0);
    check_eq("rd_en_phase", 32'(rd_en), 32'((c % 3 == 1) && (c < 3 * l + 1)));
    check_eq("wr_en_phase", 32'(wr_en), 32'((c % 3 == 0) && (c >= 3) && (c <= 3 * l)));
    if (rd_en) begin
      obs_rd_q.push_back(rd_addr);
      if (exp_rd_q.size() == 0) check_eq("rd_extra", 1, 0);
      else check_eq("rd_addr", 32'(rd_addr), 32'(exp_rd_q.pop_front()));
    end
    if (wr_en) begin
      obs_wa_q.push_back(wr_addr);
      if (exp_wa_q.size() == 0) check_eq("wr_extra", 1, 0);
      else begin
        check_eq("wr_addr", 32'(wr_addr), 32'(exp_wa_q.pop_front()));
        check_eq("wr_data", 32'(din),     32'(exp_wd_q.pop_front()));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: run one full transfer while scribbling on the inputs
  // ---------------------------------------------------------------------------
  task automatic run_xfer(input int s, input int d, input int l, input string tag);
    int  c;
    bit  seen;
    model_xfer(s, d, l);
    obs_rd_q.delete();
    obs_wa_q.delete();
    @(posedge clk); #1;
    start = 1'b1; src_base = AW'(s); dst_base = AW'(d); len = AW'(l);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 3 * l + 4) begin
      @(negedge clk);
      observe_cycle(c, l);
      if (done) begin
        check_eq({tag, "_done_cycle"}, 32'(c), 32'(3 * l + 1));
        seen = 1'b1;
      end
      @(posedge clk); #1;
      if (!seen) begin
        // Inputs are don't-care once the transfer is running.
        start    = 1'($urandom_range(0, 1));
        src_base = AW'($urandom_range(0, DEPTH - 1));
        dst_base = AW'($urandom_range(0, DEPTH - 1));
        len      = AW'($urandom_range(0, DEPTH - 1));
      end else begin
        start = 1'b0;
      end
      c++;
    end
    if (!seen) check_eq({tag, "_done_timeout"}, 0, 1);
    start = 1'b0;
    @(negedge clk);
    check_eq({tag, "_busy_after"}, 32'(busy), 0);
    check_eq({tag, "_done_after"}, 32'(done), 0);
    check_eq({tag, "_rd_left"}, 32'(exp_rd_q.size()), 0);
    check_eq({tag, "_wr_left"}, 32'(exp_wa_q.size()), 0);
    check_mem_c({tag, "_mem_c"});
  endtask

  // Start len=3, assert rst during the second WAIT (cycle 5).
  task automatic abort_xfer(input int s, input int d);
    logic [DW-1:0] first_sum;
    first_sum = mem_a[s % DEPTH] + mem_b[s % DEPTH];
    @(posedge clk); #1;
    start = 1'b1; src_base = AW'(s); dst_base = AW'(d); len = AW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_eq("abort_busy_pre", 32'(busy), 1);
      @(posedge clk); #1;
    end
    rst = 1'b1;                 // in effect at the edge ending cycle 5
    @(negedge clk);
    check_eq("abort_in_wait_busy", 32'(busy), 1);
    @(negedge clk);
    check_idle_outputs("abort_next");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(done), 0);
      check_eq("abort_no_wr",   32'(wr_en), 0);
    end
    exp_c[d % DEPTH] = first_sum;
    check_mem_c("abort_mem_c");
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    start = 1'b1; src_base = '1; dst_base = '1; len = '1;
    clr_c = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      mem_a[k] = '0; mem_b[k] = '0; exp_c[k] = '0;
    end
    qa = '0; qb = '0;

    // Reset dominates an asserted start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0; clr_c = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    // Basic three-word transfer.
    mem_a[0] = 8; mem_a[1] = 11; mem_a[2] = 27;
    mem_b[0] = 3; mem_b[1] = 28; mem_b[2] = 83;
    run_xfer(0, 8, 3, "basic");
    check_eq("basic_c8",  32'(mem_c[8]),  11);
    check_eq("basic_c9",  32'(mem_c[9]),  39);
    check_eq("basic_c10", 32'(mem_c[10]), 110);

    // Sum overflow drops the carry.
    mem_a[5] = 8'h81; mem_b[5] = 8'h83;
    run_xfer(5, 5, 1, "carry");
    check_eq("carry_c5", 32'(mem_c[5]), 32'h04);

    // Zero-length transfer.
    run_xfer(3, 3, 0, "len0");
    check_eq("len0_no_rd", 32'(obs_rd_q.size()), 0);
    check_eq("len0_no_wr", 32'(obs_wa_q.size()), 0);

    // Address wrap on both sides.
    run_xfer(14, 15, 3, "wrap");
    if (obs_rd_q.size() == 3 && obs_wa_q.size() == 3) begin
      check_eq("wrap_rd0", 32'(obs_rd_q[0]), 14);
      check_eq("wrap_rd1", 32'(obs_rd_q[1]), 15);
      check_eq("wrap_rd2", 32'(obs_rd_q[2]), 0);
      check_eq("wrap_wr0", 32'(obs_wa_q[0]), 15);
      check_eq("wrap_wr1", 32'(obs_wa_q[1]), 0);
      check_eq("wrap_wr2", 32'(obs_wa_q[2]), 1);
    end else begin
      check_eq("wrap_count", 32'(obs_rd_q.size() + obs_wa_q.size()), 6);
    end

    // Abort mid-transfer.
    abort_xfer(2, 12);

    // Randomized transfers on random memory contents.
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_a[k] = DW'($urandom_range(0, (1 << DW) - 1));
        mem_b[k] = DW'($urandom_range(0, (1 << DW) - 1));
      end
      run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
               (t < 2) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
